fifo_pixel_drain: RTL and testbench

FIFO_PIXEL_DRAIN -- requirements
Module: fifo_pixel_drain

---
 rtl/fifo_pixel_drain_pkg.sv | 11 +
 rtl/fifo_pixel_drain_line_counter.sv | 44 ++++
 rtl/fifo_pixel_drain.sv | 121 ++++++++++++
 tb/tb_fifo_pixel_drain.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pixel_drain_pkg.sv
// Shared GPU display constants: FIFO word width, pixel width and pixels per word.
package fifo_pixel_drain_pkg;

  localparam int GPU_DATA_WIDTH      = 16;
  localparam int GPU_PIX_WIDTH       = 4;
  localparam int GPU_PPW             = GPU_DATA_WIDTH / GPU_PIX_WIDTH;
  localparam int GPU_FIFO_DEPTH      = 16;
  localparam int GPU_FIFO_ADDR_WIDTH = $clog2(GPU_FIFO_DEPTH);
  localparam int GPU_LINE_PIXELS     = 640;

endpackage

// File: rtl/fifo_pixel_drain_line_counter.sv
// Pixel index within a display line; wraps at the end of the line with a one-cycle done pulse.
module line_counter #(
  parameter int LINE_PIXELS = 640,
  parameter int CNT_W       = $clog2(LINE_PIXELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_i,
  output logic [CNT_W-1:0] pix_count_o,
  output logic             line_done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_PIXELS - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (advance_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign pix_count_o = count_q;
  assign line_done_o = done_q;

endmodule

// File: rtl/fifo_pixel_drain.sv
// Drains FIFO words into a one-pixel-per-request display stream, LSB pixel first,
// with prefetch, same-cycle bypass, seamless refill and sticky underrun tracking.
module fifo_pixel_drain import fifo_pixel_drain_pkg::*; #(
  parameter int DATA_WIDTH  = GPU_DATA_WIDTH,
  parameter int PIX_WIDTH   = GPU_PIX_WIDTH,
  parameter int LINE_PIXELS = GPU_LINE_PIXELS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_read_data,
  output logic                           fifo_ren,
  input  logic                           pix_req,
  input  logic                           underrun_clr,
  output logic [PIX_WIDTH-1:0]           pix_data,
  output logic                           pix_valid,
  output logic                           line_done,
  output logic [$clog2(LINE_PIXELS)-1:0] pix_count,
  output logic                           underrun,
  output logic [7:0]                     underrun_count
);

  localparam int PPW   = DATA_WIDTH / PIX_WIDTH;
  localparam int CNT_W = $clog2(PPW + 1);
  localparam logic [CNT_W-1:0] PPW_CNT = CNT_W'(PPW);

  logic [DATA_WIDTH-1:0] hold_word_q, hold_word_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [PIX_WIDTH-1:0]  pix_data_q, pixel;
  logic                  pix_valid_q, underrun_q;
  logic [7:0]            underrun_count_q;
  logic                  ren, served, starved;

  // EMPTY means hold_cnt is zero; LOADED otherwise. A pop happens only on prefetch,
  // bypass or refill of the last held pixel, and always needs a word at the FIFO head.
  always_comb begin
    hold_word_d = hold_word_q;
    hold_cnt_d  = hold_cnt_q;
    ren         = 1'b0;
    served      = 1'b0;
    starved     = 1'b0;
    pixel       = '0;
    if (hold_cnt_q == '0) begin
      if (!fifo_empty) begin
        ren = 1'b1;
        if (pix_req) begin
          served      = 1'b1;
          pixel       = fifo_read_data[PIX_WIDTH-1:0];
          hold_word_d = fifo_read_data >> PIX_WIDTH;
          hold_cnt_d  = PPW_CNT - 1'b1;
        end else begin
          hold_word_d = fifo_read_data;
          hold_cnt_d  = PPW_CNT;
        end
      end else if (pix_req) begin
        starved = 1'b1;
      end
    end else if (pix_req) begin
      served = 1'b1;
      pixel  = hold_word_q[PIX_WIDTH-1:0];
      if (hold_cnt_q == CNT_W'(1)) begin
        if (!fifo_empty) begin
          ren         = 1'b1;
          hold_word_d = fifo_read_data;
          hold_cnt_d  = PPW_CNT;
        end else begin
          hold_word_d = '0;
          hold_cnt_d  = '0;
        end
      end else begin
        hold_word_d = hold_word_q >> PIX_WIDTH;
        hold_cnt_d  = hold_cnt_q - 1'b1;
      end
    end
  end

  assign fifo_ren = ren & ~reset;

  // A starved request in the same cycle as a clear wins, restarting the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_word_q      <= '0;
      hold_cnt_q       <= '0;
      pix_data_q       <= '0;
      pix_valid_q      <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      hold_word_q <= hold_word_d;
      hold_cnt_q  <= hold_cnt_d;
      pix_valid_q <= served;
      if (served) begin
        pix_data_q <= pixel;
      end else if (starved) begin
        pix_data_q <= '0;
      end
      if (starved) begin
        underrun_q       <= 1'b1;
        underrun_count_q <= underrun_clr ? 8'd1 :
                            (underrun_count_q == 8'hFF) ? 8'hFF : underrun_count_q + 8'd1;
      end else if (underrun_clr) begin
        underrun_q       <= 1'b0;
        underrun_count_q <= '0;
      end
    end
  end

  line_counter #(.LINE_PIXELS(LINE_PIXELS)) u_line_counter (
    .clk         (clk),
    .reset       (reset),
    .advance_i   (pix_req),
    .pix_count_o (pix_count),
    .line_done_o (line_done)
  );

  assign pix_data       = pix_data_q;
  assign pix_valid      = pix_valid_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_fifo_pixel_drain.sv
// Bench for fifo_pixel_drain: models the upstream FIFO and the pixel stream as queues.
module tb_fifo_pixel_drain;

  localparam int DW   = 16;
  localparam int PW   = 4;
  localparam int LINE = 8;
  localparam int PPW  = DW / PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data;
  logic          fifo_ren;
  logic          pix_req = 1'b0;
  logic          underrun_clr = 1'b0;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          line_done;
  logic [2:0]    pix_count;
  logic          underrun;
  logic [7:0]    underrun_count;

  int total = 0;
  int bad = 0;

  // Reference state: words still in the upstream FIFO, and every pixel not yet displayed.
  logic [DW-1:0] fifoQ[$];
  logic [PW-1:0] pixQ[$];
  logic [PW-1:0] expData;
  logic          expValid, expLineDone, expUnder;
  int            expCount, expUcnt;
  logic          lastRen;
  int            renPulses, renBad;

  fifo_pixel_drain #(.DATA_WIDTH(DW), .PIX_WIDTH(PW), .LINE_PIXELS(LINE)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_ren       (fifo_ren),
    .pix_req        (pix_req),
    .underrun_clr   (underrun_clr),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .line_done      (line_done),
    .pix_count      (pix_count),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  task automatic updatePins();
    fifo_empty     = (fifoQ.size() == 0);
    fifo_read_data = (fifoQ.size() != 0) ? fifoQ[0] : '0;
  endtask

  task automatic pushWord(input logic [DW-1:0] w);
    logic [DW-1:0] t;
    fifoQ.push_back(w);
    t = w;
    for (int k = 0; k < PPW; k++) begin
      pixQ.push_back(t[PW-1:0]);
      t = t >> PW;
    end
    updatePins();
  endtask

  // One clock: drive at the falling edge, predict the pixel stream, return at the next falling edge.
  task automatic applyStimulus(input logic req, input logic clr);
    int held;
    pix_req = req;
    underrun_clr = clr;
    #1;
    lastRen = fifo_ren;
    if (fifo_ren) renPulses++;
    if (fifo_ren && fifo_empty) renBad++;
    expLineDone = 1'b0;
    if (reset) begin
      held = pixQ.size() - PPW * fifoQ.size();
      for (int k = 0; k < held; k++) void'(pixQ.pop_front());
      expData = '0; expValid = 1'b0; expUnder = 1'b0; expUcnt = 0; expCount = 0;
    end else begin
      expValid = 1'b0;
      if (req) begin
        if (pixQ.size() > 0) begin
          expValid = 1'b1;
          expData  = pixQ.pop_front();
          if (clr) begin expUnder = 1'b0; expUcnt = 0; end
        end else begin
          expData  = '0;
          expUnder = 1'b1;
          expUcnt  = clr ? 1 : ((expUcnt >= 255) ? 255 : expUcnt + 1);
        end
        expLineDone = (expCount == LINE - 1);
        expCount    = (expCount + 1) % LINE;
      end else if (clr) begin
        expUnder = 1'b0; expUcnt = 0;
      end
    end
    @(posedge clk);
    #1;
    if (lastRen && fifoQ.size() > 0) void'(fifoQ.pop_front());
    updatePins();
    @(negedge clk);
  endtask

  task automatic startClean();
    fifoQ.delete();
    pixQ.delete();
    updatePins();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    renPulses = 0;
    renBad = 0;
  endtask

  task automatic test_reset();
    fifoQ.delete();
    pixQ.delete();
    pushWord(16'h1234);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
    total++; if (lastRen !== 1'b0) begin bad++; $display("[TB] FAIL reset_ren: got %b want 0", lastRen); end
    total++; if (pix_data !== 4'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", pix_data); end
    total++; if (pix_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", pix_valid); end
    total++; if (line_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", line_done); end
    total++; if (pix_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", pix_count); end
    total++; if (underrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_under: got %b want 0", underrun); end
    total++; if (underrun_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_ucnt: got %0d want 0", underrun_count); end
    total++; if (fifoQ.size() != 1) begin bad++; $display("[TB] FAIL reset_nopop: got %0d words want 1", fifoQ.size()); end
  endtask

  task automatic test_stream();
    int dones = 0;
    startClean();
    pushWord(16'h4321);
    pushWord(16'h8765);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (line_done) dones++;
      total++; if (pix_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid%0d: got %b want 1", i, pix_valid); end
      total++; if (pix_data !== 4'(i + 1)) begin bad++; $display("[TB] FAIL stream_data%0d: got %h want %h", i, pix_data, i + 1); end
    end
    total++; if (renPulses != 2) begin bad++; $display("[TB] FAIL stream_pops: got %0d want 2", renPulses); end
    total++; if (dones != 1 || line_done !== 1'b1) begin bad++; $display("[TB] FAIL line_done: got %0d pulses last=%b want 1 on 8th", dones, line_done); end
    total++; if (pix_count !== 3'd0) begin bad++; $display("[TB] FAIL line_wrap: got %0d want 0", pix_count); end
  endtask

  task automatic test_underrun();
    startClean();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    total++; if (pix_valid !== 1'b0 || pix_data !== 4'h0) begin bad++; $display("[TB] FAIL starve_out: got v=%b d=%h want v=0 d=0", pix_valid, pix_data); end
    total++; if (underrun !== 1'b1) begin bad++; $display("[TB] FAIL starve_flag: got %b want 1", underrun); end
    total++; if (underrun_count !== 8'd3) begin bad++; $display("[TB] FAIL starve_cnt: got %0d want 3", underrun_count); end
    total++; if (pix_count !== 3'd3) begin bad++; $display("[TB] FAIL starve_pixcnt: got %0d want 3", pix_count); end
  endtask

  task automatic test_bypass();
    logic [3:0] want[4] = '{4'h3, 4'hC, 4'h5, 4'hA};
    startClean();
    applyStimulus(1'b0, 1'b0);
    pushWord(16'hA5C3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i == 0) begin
        total++; if (lastRen !== 1'b1) begin bad++; $display("[TB] FAIL bypass_ren: got %b want 1", lastRen); end
      end
      total++; if (pix_valid !== 1'b1 || pix_data !== want[i]) begin bad++; $display("[TB] FAIL bypass_pix%0d: got v=%b d=%h want v=1 d=%h", i, pix_valid, pix_data, want[i]); end
    end
  endtask

  task automatic test_reset_midword();
    startClean();
    pushWord(16'h4321);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    total++; if (pix_data !== 4'h2) begin bad++; $display("[TB] FAIL mid_pre: got %h want 2", pix_data); end
    pushWord(16'hDCBA);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
    total++; if (lastRen !== 1'b0 || fifoQ.size() != 1) begin bad++; $display("[TB] FAIL mid_nopop: got ren=%b words=%0d want ren=0 words=1", lastRen, fifoQ.size()); end
    total++; if (pix_valid !== 1'b0 || pix_data !== 4'h0 || pix_count !== 3'd0) begin bad++; $display("[TB] FAIL mid_outs: got v=%b d=%h c=%0d want all 0", pix_valid, pix_data, pix_count); end
    applyStimulus(1'b1, 1'b0);
    total++; if (pix_valid !== 1'b1 || pix_data !== 4'hA) begin bad++; $display("[TB] FAIL mid_restart: got v=%b d=%h want v=1 d=a", pix_valid, pix_data); end
  endtask

  task automatic test_underrun_clr();
    startClean();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    total++; if (underrun !== 1'b1 || underrun_count !== 8'd1) begin bad++; $display("[TB] FAIL clr_race: got u=%b c=%0d want u=1 c=1", underrun, underrun_count); end
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b0);
    total++; if (underrun_count !== 8'd255) begin bad++; $display("[TB] FAIL sat: got %0d want 255", underrun_count); end
    applyStimulus(1'b0, 1'b1);
    total++; if (underrun !== 1'b0 || underrun_count !== 8'd0) begin bad++; $display("[TB] FAIL clr: got u=%b c=%0d want 0", underrun, underrun_count); end
  endtask

  task automatic test_random();
    startClean();
    for (int i = 0; i < 600; i++) begin
      if (fifoQ.size() < 3 && $urandom_range(0, 99) < 35) pushWord(16'($urandom));
      reset = ($urandom_range(0, 99) < 2);
      applyStimulus(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 5));
      reset = 1'b0;
      total++; if (pix_valid !== expValid) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", i, pix_valid, expValid); end
      total++; if (pix_data !== expData) begin bad++; $display("[TB] FAIL rnd_data@%0d: got %h want %h", i, pix_data, expData); end
      total++; if (line_done !== expLineDone) begin bad++; $display("[TB] FAIL rnd_done@%0d: got %b want %b", i, line_done, expLineDone); end
      total++; if (pix_count !== 3'(expCount)) begin bad++; $display("[TB] FAIL rnd_pixcnt@%0d: got %0d want %0d", i, pix_count, expCount); end
      total++; if (underrun !== expUnder) begin bad++; $display("[TB] FAIL rnd_under@%0d: got %b want %b", i, underrun, expUnder); end
      total++; if (underrun_count !== 8'(expUcnt)) begin bad++; $display("[TB] FAIL rnd_ucnt@%0d: got %0d want %0d", i, underrun_count, expUcnt); end
    end
    total++; if (renBad != 0) begin bad++; $display("[TB] FAIL ren_when_empty: got %0d want 0", renBad); end
  endtask

  initial begin
    renPulses = 0;
    renBad = 0;
    updatePins();
    @(negedge clk);
    test_reset();
    test_stream();
    test_underrun();
    test_bypass();
    test_reset_midword();
    test_underrun_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
